// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the two-master round-robin bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bus_arb_pkg;

    // The grant output is the state register itself, so the encoding is one-hot per master.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } arb_state_t;

    localparam int M0 = 0;
    localparam int M1 = 1;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/bus_arb_watchdog.sv
// Grant-duration watchdog: counts cycles spent in a grant and flags the last allowed one.
// Latency: expire is combinational from the registered count (asserted on cycle TIMEOUT_CYCLES of a grant).
// Backpressure: none; a TIMEOUT_CYCLES of 0 disables expiry entirely.
module bus_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    input  logic en,
    output logic expire
);

    // Keep at least one bit so a disabled watchdog still elaborates cleanly.
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LAST_CNT = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CW-1:0] MAX_CNT  = '1;

    logic [CW-1:0] count;

    // Clear outside a grant, count up while granted, and saturate instead of wrapping.
    always_ff @(posedge clk) begin
        if (!resetn || clr) begin
            count <= '0;
        end else if (en && (count != MAX_CNT)) begin
            count <= count + CW'(1);
        end
    end

    assign expire = (TIMEOUT_CYCLES > 0) && en && (count == LAST_CNT);

endmodule

// File: rtl/bus_arbiter2.sv
// Two-master round-robin arbiter for the shared native memory bus, one transaction per grant.
// Latency: request in IDLE -> s_valid next cycle; completion ready is same-cycle with s_ready; >=1 idle cycle between grants.
// Backpressure: masters hold valid until their ready; a hung slave is cut off by the watchdog with an error response.
module bus_arbiter2
    import bus_arb_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,

    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,

    output logic [1:0]  grant,
    output logic        timeout_err
);

    arb_state_t state, state_nxt;
    logic       last_srv, last_srv_nxt;
    logic       granted;
    logic       gidx;
    logic       wd_expire;

    logic        cur_valid;
    logic        cur_instr;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [3:0]  cur_wstrb;
    logic        done;
    logic [31:0] done_rdata;

    assign granted = (state != IDLE);
    assign gidx    = (state == GNT1);
    assign grant   = state;

    bus_arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .resetn (resetn),
        .clr    (!granted),
        .en     (granted),
        .expire (wd_expire)
    );

    // State and last-served pointer; pointer resets to m1 so m0 wins the first tie.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            last_srv <= 1'(M1);
        end else begin
            state    <= state_nxt;
            last_srv <= last_srv_nxt;
        end
    end

    // Select the owning master's request fields; master 1 never issues instruction fetches.
    always_comb begin
        cur_valid = gidx ? m1_valid : m0_valid;
        cur_instr = gidx ? 1'b0     : m0_instr;
        cur_addr  = gidx ? m1_addr  : m0_addr;
        cur_wdata = gidx ? m1_wdata : m0_wdata;
        cur_wstrb = gidx ? m1_wstrb : m0_wstrb;
    end

    // Arbitration, completion/abort/timeout handling and output steering.
    always_comb begin
        state_nxt    = state;
        last_srv_nxt = last_srv;
        s_valid      = 1'b0;
        s_instr      = 1'b0;
        s_addr       = '0;
        s_wdata      = '0;
        s_wstrb      = '0;
        m0_ready     = 1'b0;
        m0_rdata     = '0;
        m1_ready     = 1'b0;
        m1_rdata     = '0;
        timeout_err  = 1'b0;
        done         = 1'b0;
        done_rdata   = '0;

        case (state)
            IDLE: begin
                if (m0_valid && m1_valid) begin
                    state_nxt = (last_srv == 1'(M0)) ? GNT1 : GNT0;
                end else if (m0_valid) begin
                    state_nxt = GNT0;
                end else if (m1_valid) begin
                    state_nxt = GNT1;
                end
            end
            GNT0, GNT1: begin
                s_valid = cur_valid;
                s_instr = cur_instr;
                s_addr  = cur_addr;
                s_wdata = cur_wdata;
                s_wstrb = cur_wstrb;
                if (s_ready) begin
                    done         = 1'b1;
                    done_rdata   = s_rdata;
                    state_nxt    = IDLE;
                    last_srv_nxt = gidx;
                end else if (!cur_valid) begin
                    // Master withdrew: release the bus without a response or pointer update.
                    state_nxt = IDLE;
                end else if (wd_expire) begin
                    done         = 1'b1;
                    done_rdata   = ERR_RDATA;
                    timeout_err  = 1'b1;
                    s_valid      = 1'b0;
                    state_nxt    = IDLE;
                    last_srv_nxt = gidx;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (gidx) begin
            m1_ready = done;
            m1_rdata = done_rdata;
        end else begin
            m0_ready = done;
            m0_rdata = done_rdata;
        end
    end

endmodule

// File: tb/tb_bus_arbiter2.sv
// Self-checking bench for bus_arbiter2 against a transaction-rule reference model.
// Latency: n/a.
// Backpressure: bench drives slave ready directly.
module tb_bus_arbiter2;

    localparam int          TO  = 8;
    localparam logic [31:0] ERR = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        m0_valid = 0, m0_instr = 0, m1_valid = 0;
    logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
    logic [3:0]  m0_wstrb = 0, m1_wstrb = 0;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid, s_instr, s_ready = 0;
    logic [31:0] s_addr, s_wdata, s_rdata = 0;
    logic [3:0]  s_wstrb;
    logic [1:0]  grant;
    logic        timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    bus_arbiter2 #(.TIMEOUT_CYCLES(TO), .ERR_RDATA(ERR)) dut (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(grant), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    wire [138:0] dut_vec = {s_valid, s_instr, s_addr, s_wdata, s_wstrb,
                            m0_ready, m0_rdata, m1_ready, m1_rdata, grant, timeout_err};

    // Reference model: owner (-1 none), last served master, cycles spent in the current grant.
    int   own  = -1;
    int   last = 1;
    int   gcnt = 0;
    logic m_end, m_abort;
    logic [138:0] exp_vec;

    task automatic model_eval();
        logic        v, fin, e_sv, e_si, e_r0, e_r1, e_to;
        logic [31:0] rd, e_sa, e_sd, e_d0, e_d1;
        logic [3:0]  e_ss;
        logic [1:0]  e_g;
        v = 0; fin = 0; rd = 0; e_sv = 0; e_si = 0; e_sa = 0; e_sd = 0; e_ss = 0;
        e_r0 = 0; e_r1 = 0; e_d0 = 0; e_d1 = 0; e_to = 0;
        m_end = 0; m_abort = 0;
        e_g = (own == 0) ? 2'b01 : (own == 1) ? 2'b10 : 2'b00;
        if (own >= 0) begin
            v    = (own == 1) ? m1_valid : m0_valid;
            e_sv = v;
            e_si = (own == 1) ? 1'b0 : m0_instr;
            e_sa = (own == 1) ? m1_addr : m0_addr;
            e_sd = (own == 1) ? m1_wdata : m0_wdata;
            e_ss = (own == 1) ? m1_wstrb : m0_wstrb;
            if (s_ready) begin
                fin = 1; rd = s_rdata;
            end else if (!v) begin
                m_abort = 1;
            end else if (gcnt == TO - 1) begin
                fin = 1; rd = ERR; e_to = 1; e_sv = 0;
            end
            m_end = fin;
            if (fin && own == 1) begin e_r1 = 1; e_d1 = rd; end
            if (fin && own == 0) begin e_r0 = 1; e_d0 = rd; end
        end
        exp_vec = {e_sv, e_si, e_sa, e_sd, e_ss, e_r0, e_d0, e_r1, e_d1, e_g, e_to};
    endtask

    task automatic model_advance();
        model_eval();
        if (!resetn) begin
            own = -1; last = 1; gcnt = 0;
        end else if (own < 0) begin
            gcnt = 0;
            if (m0_valid && m1_valid) own = (last == 0) ? 1 : 0;
            else if (m0_valid)        own = 0;
            else if (m1_valid)        own = 1;
        end else if (m_end) begin
            last = own; own = -1;
        end else if (m_abort) begin
            own = -1;
        end else begin
            gcnt++;
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are observed on the falling edge.
    task automatic advance();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        model_eval();
    endtask

    task automatic drive_m(input int m, input logic v, input logic ins, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        if (m == 0) begin
            m0_valid = v; m0_instr = ins; m0_addr = a; m0_wdata = d; m0_wstrb = s;
        end else begin
            m1_valid = v; m1_addr = a; m1_wdata = d; m1_wstrb = s;
        end
    endtask

    task automatic do_reset();
        resetn = 0;
        drive_m(0, 0, 0, 0, 0, 0);
        drive_m(1, 0, 0, 0, 0, 0);
        s_ready = 0; s_rdata = 0;
        advance();
        resetn = 1;
    endtask

    task automatic test_reset();
        resetn = 0;
        drive_m(0, 1, 1, 32'h10, 32'h20, 4'hF);
        drive_m(1, 1, 0, 32'h30, 32'h40, 4'h3);
        s_ready = 1; s_rdata = 32'hDEAD_BEEF;
        advance();
        advance();
        settle();
        n_checks++;
        if (dut_vec !== 139'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want 0", dut_vec);
        end
        do_reset();
    endtask

    task automatic test_single_read();
        do_reset();
        drive_m(0, 1, 1, 32'h0000_0100, 32'h0, 4'h0);
        settle();
        n_checks++;
        if (s_valid !== 1'b0) begin n_fail++; $display("FAIL single_idle_cycle: s_valid got %b want 0", s_valid); end
        advance();
        for (int i = 0; i < 3; i++) begin
            settle();
            n_checks++;
            if (grant !== 2'b01 || m0_ready !== 1'b0 || s_valid !== 1'b1 || s_addr !== 32'h100 || s_instr !== 1'b1) begin
                n_fail++; $display("FAIL single_wait: grant %b ready %b s_valid %b addr %h instr %b want 01 0 1 00000100 1",
                                   grant, m0_ready, s_valid, s_addr, s_instr);
            end
            advance();
        end
        s_ready = 1; s_rdata = 32'h1234_5678;
        settle();
        n_checks++;
        if (m0_ready !== 1'b1 || m0_rdata !== 32'h1234_5678 || grant !== 2'b01 || m1_ready !== 1'b0) begin
            n_fail++; $display("FAIL single_complete: ready %b rdata %h grant %b m1_ready %b want 1 12345678 01 0",
                               m0_ready, m0_rdata, grant, m1_ready);
        end
        advance();
        drive_m(0, 0, 0, 0, 0, 0);
        s_ready = 0;
        settle();
        n_checks++;
        if (grant !== 2'b00 || s_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_release: grant %b s_valid %b want 00 0", grant, s_valid);
        end
        advance();
    endtask

    task automatic test_tie();
        int   order[$];
        logic d0, d1, prev_done;
        d0 = 0; d1 = 0; prev_done = 0;
        do_reset();
        drive_m(0, 1, 0, 32'h0000_1000, 32'h0, 4'h0);
        drive_m(1, 1, 0, 32'h0000_2000, 32'h0, 4'h0);
        s_ready = 1; s_rdata = 32'h0000_00AA;
        for (int c = 0; c < 20 && order.size() < 2; c++) begin
            settle();
            n_checks++;
            if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL tie_model: got %h want %h", dut_vec, exp_vec); end
            n_checks++;
            if ((m0_ready && m1_ready) || (prev_done && s_valid)) begin
                n_fail++; $display("FAIL tie_overlap: m0_ready %b m1_ready %b s_valid %b after completion %b", m0_ready, m1_ready, s_valid, prev_done);
            end
            prev_done = m0_ready | m1_ready;
            if (m0_ready) begin order.push_back(0); d0 = 1; end
            if (m1_ready) begin order.push_back(1); d1 = 1; end
            advance();
            if (d0) m0_valid = 0;
            if (d1) m1_valid = 0;
        end
        n_checks++;
        if (order.size() != 2 || order[0] != 0 || order[1] != 1) begin
            n_fail++; $display("FAIL tie_order: completions %0d first %0d want 2 completions m0 then m1",
                               order.size(), (order.size() > 0) ? order[0] : -1);
        end
        s_ready = 0;
        advance();
    endtask

    task automatic test_back_to_back();
        logic [31:0] pa[2], pd[2];
        int k;
        k = 0;
        do_reset();
        for (int m = 0; m < 2; m++) begin
            pa[m] = $urandom; pd[m] = $urandom;
            drive_m(m, 1, 0, pa[m], pd[m], 4'hF);
        end
        s_ready = 1;
        for (int c = 0; c < 80 && k < 10; c++) begin
            int fin_m;
            fin_m = -1;
            settle();
            n_checks++;
            if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL b2b_model: got %h want %h", dut_vec, exp_vec); end
            if (s_valid && s_ready) begin
                fin_m = k % 2;
                n_checks++;
                if (grant !== ((fin_m == 1) ? 2'b10 : 2'b01) || s_addr !== pa[fin_m] ||
                    s_wdata !== pd[fin_m] || s_wstrb !== 4'hF) begin
                    n_fail++; $display("FAIL b2b_write%0d: grant %b addr %h data %h strb %h want owner m%0d addr %h data %h strb f",
                                       k, grant, s_addr, s_wdata, s_wstrb, fin_m, pa[fin_m], pd[fin_m]);
                end
                k++;
            end
            advance();
            if (fin_m >= 0) begin
                pa[fin_m] = $urandom; pd[fin_m] = $urandom;
                drive_m(fin_m, 1, 0, pa[fin_m], pd[fin_m], 4'hF);
            end
        end
        n_checks++;
        if (k != 10) begin n_fail++; $display("FAIL b2b_count: got %0d writes want 10", k); end
        drive_m(0, 0, 0, 0, 0, 0);
        drive_m(1, 0, 0, 0, 0, 0);
        s_ready = 0;
        advance();
    endtask

    task automatic test_timeout();
        int   gc;
        logic seen, served;
        gc = 0; seen = 0; served = 0;
        do_reset();
        drive_m(1, 1, 0, 32'h4000_0000, 32'h0, 4'h0);
        for (int c = 0; c < 20 && !seen; c++) begin
            settle();
            n_checks++;
            if (dut_vec !== exp_vec) begin n_fail++; $display("FAIL timeout_model: got %h want %h", dut_vec, exp_vec); end
            if (grant == 2'b10) begin
                gc++;
                if (gc < TO) begin
                    n_checks++;
                    if (m1_ready !== 1'b0 || timeout_err !== 1'b0) begin
                        n_fail++; $display("FAIL timeout_early: cycle %0d ready %b err %b want 0 0", gc, m1_ready, timeout_err);
                    end
                end else begin
                    seen = 1;
                    n_checks++;
                    if (m1_ready !== 1'b1 || timeout_err !== 1'b1 || m1_rdata !== ERR || s_valid !== 1'b0) begin
                        n_fail++; $display("FAIL timeout_fire: ready %b err %b rdata %h s_valid %b want 1 1 ffffffff 0",
                                           m1_ready, timeout_err, m1_rdata, s_valid);
                    end
                end
            end
            advance();
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL timeout_never: grant cycles %0d want %0d", gc, TO); end
        drive_m(1, 0, 0, 0, 0, 0);
        drive_m(0, 1, 0, 32'h0000_0200, 32'h0, 4'h0);
        s_ready = 1; s_rdata = 32'hCAFE_0001;
        for (int c = 0; c < 6 && !served; c++) begin
            settle();
            if (m0_ready) begin
                served = 1;
                n_checks++;
                if (grant !== 2'b01 || m0_rdata !== 32'hCAFE_0001 || timeout_err !== 1'b0) begin
                    n_fail++; $display("FAIL timeout_next: grant %b rdata %h err %b want 01 cafe0001 0", grant, m0_rdata, timeout_err);
                end
            end
            advance();
            if (served) m0_valid = 0;
        end
        n_checks++;
        if (!served) begin n_fail++; $display("FAIL timeout_next_never: m0 got no ready want one"); end
        s_ready = 0;
        advance();
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive_m(1, 1, 0, 32'h0000_3000, 32'h5555_AAAA, 4'h3);
        advance();
        resetn = 0;
        m0_valid = 1; m0_instr = 1; m0_addr = 32'h0000_0400;
        settle();
        n_checks++;
        if (grant !== 2'b10) begin n_fail++; $display("FAIL rstmid_pre: grant %b want 10", grant); end
        advance();
        settle();
        n_checks++;
        if (dut_vec !== 139'd0) begin n_fail++; $display("FAIL rstmid_zero: got %h want 0", dut_vec); end
        advance();
        resetn = 1;
        advance();
        settle();
        n_checks++;
        if (grant !== 2'b01 || s_addr !== 32'h0000_0400) begin
            n_fail++; $display("FAIL rstmid_tie: grant %b addr %h want 01 00000400", grant, s_addr);
        end
        drive_m(0, 0, 0, 0, 0, 0);
        drive_m(1, 0, 0, 0, 0, 0);
        advance();
        advance();
    endtask

    task automatic test_abort();
        do_reset();
        drive_m(0, 1, 0, 32'h0000_0500, 32'h0, 4'h0);
        advance();
        drive_m(1, 1, 0, 32'h0000_0600, 32'h0, 4'h0);
        settle();
        n_checks++;
        if (grant !== 2'b01) begin n_fail++; $display("FAIL abort_grant: grant %b want 01", grant); end
        advance();
        m0_valid = 0;
        settle();
        n_checks++;
        if (m0_ready !== 1'b0 || m1_ready !== 1'b0 || s_valid !== 1'b0 || timeout_err !== 1'b0) begin
            n_fail++; $display("FAIL abort_no_ready: m0_ready %b m1_ready %b s_valid %b err %b want 0 0 0 0",
                               m0_ready, m1_ready, s_valid, timeout_err);
        end
        advance();
        settle();
        n_checks++;
        if (grant !== 2'b00 || m1_ready !== 1'b0) begin n_fail++; $display("FAIL abort_idle: grant %b want 00", grant); end
        advance();
        settle();
        n_checks++;
        if (grant !== 2'b10 || s_addr !== 32'h0000_0600 || s_valid !== 1'b1) begin
            n_fail++; $display("FAIL abort_next: grant %b addr %h s_valid %b want 10 00000600 1", grant, s_addr, s_valid);
        end
        drive_m(1, 0, 0, 0, 0, 0);
        advance();
    endtask

    task automatic test_random();
        logic act[2];
        int   errs;
        act[0] = 0; act[1] = 0; errs = 0;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            for (int m = 0; m < 2; m++) begin
                if (!act[m] && ($urandom_range(3) == 0)) begin
                    act[m] = 1;
                    drive_m(m, 1, 1'($urandom), $urandom, $urandom,
                            ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom));
                end else if (act[m] && ($urandom_range(15) == 0)) begin
                    act[m] = 0;
                    drive_m(m, 0, 0, 0, 0, 0);
                end else if (!act[m]) begin
                    drive_m(m, 0, 0, 0, 0, 0);
                end
            end
            s_ready = ($urandom_range(2) == 0);
            s_rdata = $urandom;
            settle();
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_fail++; errs++;
                if (errs < 10) $display("FAIL random_cycle%0d: got %h want %h", c, dut_vec, exp_vec);
            end
            if (m0_ready) act[0] = 0;
            if (m1_ready) act[1] = 0;
            advance();
        end
        drive_m(0, 0, 0, 0, 0, 0);
        drive_m(1, 0, 0, 0, 0, 0);
        s_ready = 0;
        advance();
    endtask

    initial begin
        #1;
        test_reset();
        test_single_read();
        test_tie();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish within budget");
        $fatal(1, "bench time limit");
    end

endmodule
